// File: rtl/l2_mem_pkg.sv
// Shared types and widths for the L2 memory responder.
// Imported by the responder top and its storage array.
package l2_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND,
        RECOVER
    } responder_state_t;

    localparam int L2_DATA_WIDTH   = 32;
    localparam int L2_ADDR_WIDTH   = 32;
    localparam int L2_OFFSET_WIDTH = 2;

endpackage

// File: rtl/l2_storage_sram.sv
// Single-port synchronous word array, registered read, no reset.
// A write in the same cycle as a read wins and leaves read_data untouched.
module l2_storage_sram
    import l2_mem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic                     read_enable,
    input  logic [IDX_W-1:0]         index,
    input  logic [L2_DATA_WIDTH-1:0] write_data,
    output logic [L2_DATA_WIDTH-1:0] read_data
);

    logic [L2_DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[index] <= write_data;
        end else if (read_enable) begin
            read_data <= mem[index];
        end
    end

endmodule

// File: rtl/l2_memory_responder.sv
// L2 stand-in: fixed-latency single-word read/write responder
// with a one-cycle ready pulse and completed-transaction counters.
module l2_memory_responder
    import l2_mem_pkg::*;
#(
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     l2_request,
    input  logic                     l2_write_enable,
    input  logic [L2_ADDR_WIDTH-1:0] l2_address,
    input  logic [L2_DATA_WIDTH-1:0] l2_write_data,
    output logic [L2_DATA_WIDTH-1:0] l2_response_data,
    output logic                     l2_ready,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     rd_count,
    output logic [CNT_WIDTH-1:0]     wr_count
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ?
                             READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LATENCY - 1);

    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
        $error("MEM_WORDS must be a power of two and at least 2");
    end
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_lat
        $error("READ_LATENCY and WRITE_LATENCY must be at least 1");
    end

    responder_state_t         state;
    logic [LAT_W-1:0]         lat_cnt;
    logic                     wr_q;
    logic [IDX_W-1:0]         idx_q;
    logic [L2_DATA_WIDTH-1:0] wdata_q;
    logic                     data_ok;
    logic                     fire;
    logic                     sram_we;
    logic                     sram_re;
    logic [L2_DATA_WIDTH-1:0] sram_rdata;
    logic                     addr_unused;

    assign addr_unused = ^{l2_address[L2_ADDR_WIDTH-1:IDX_W+L2_OFFSET_WIDTH],
                           l2_address[L2_OFFSET_WIDTH-1:0]};

    // Store access happens on the WAIT -> RESPOND edge.
    assign fire    = (state == WAIT) && (lat_cnt == '0);
    assign sram_we = fire && wr_q;
    assign sram_re = fire && !wr_q;
    assign busy    = (state != IDLE);

    // The array has no reset, so data is masked to zero until a read lands.
    assign l2_response_data = data_ok ? sram_rdata : '0;

    l2_storage_sram #(
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W)
    ) u_sram (
        .clk         (clk),
        .write_enable(sram_we),
        .read_enable (sram_re),
        .index       (idx_q),
        .write_data  (wdata_q),
        .read_data   (sram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            data_ok  <= 1'b0;
            l2_ready <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (l2_request) begin
                        wr_q    <= l2_write_enable;
                        idx_q   <= l2_address[L2_OFFSET_WIDTH +: IDX_W];
                        wdata_q <= l2_write_data;
                        lat_cnt <= l2_write_enable ? WR_LOAD : RD_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        l2_ready <= 1'b1;
                        data_ok  <= data_ok | !wr_q;
                        state    <= RESPOND;
                    end
                end
                RESPOND: begin
                    l2_ready <= 1'b0;
                    if (wr_q) begin
                        wr_count <= wr_count + 1'b1;
                    end else begin
                        rd_count <= rd_count + 1'b1;
                    end
                    state <= RECOVER;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/l2_memory_responder.md
Name: l2_memory_responder

Overview:
- Lower-memory (L2) responder for the L1 data cache's L2 request interface: accepts single-word read/write requests, services them from a word-organised backing store after a fixed latency, and returns a one-cycle l2_ready pulse.
- Serves as the simulation and FPGA stand-in for the next memory level. Also provides transaction counters for performance and debug.

Parameters:
- MEM_WORDS, 4096, backing-store depth in 32-bit words; must be a power of two and at least 2.
- READ_LATENCY, 4, cycles from request acceptance to l2_ready for reads; must be at least 1.
- WRITE_LATENCY, 2, cycles from request acceptance to l2_ready for writes; must be at least 1.
- CNT_WIDTH, 16, width of the transaction counters.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- l2_request  input  1  request valid; held by the initiator until it samples l2_ready.
- l2_write_enable  input  1  1 = write, 0 = read; qualified by l2_request.
- l2_address  input  32  byte address; bits [1:0] ignored.
- l2_write_data  input  32  write data.
- l2_response_data  output  32  read data; valid while l2_ready=1 for a read, then held.
- l2_ready  output  1  one-cycle completion pulse.
- busy  output  1  1 while a transaction is in flight (any state other than IDLE).
- rd_count  output  CNT_WIDTH  completed reads; wraps.
- wr_count  output  CNT_WIDTH  completed writes; wraps.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state to IDLE;
  - l2_ready=0, l2_response_data=0;
  - rd_count=0, wr_count=0.
  - Backing-store contents are not reset.
- Word index = l2_address[2 +: $clog2(MEM_WORDS)]. Upper address bits are ignored, so addresses alias.
- State machine:
  - IDLE: on a rising edge with l2_request=1, latch write_enable, index and write_data. Load lat_cnt with (write ? WRITE_LATENCY : READ_LATENCY) - 1, then go to WAIT.
  - WAIT: if lat_cnt != 0, decrement; else go to RESPOND.
    - On that transition edge, a write commits to the store.
    - On that transition edge, a read issues the store read; its data is registered straight into l2_response_data.
    - On that transition edge, set l2_ready<=1.
  - RESPOND: l2_ready is 1 for exactly this cycle. On exit:
    - l2_ready<=0;
    - increment rd_count or wr_count;
    - go to RECOVER.
  - RECOVER: one cycle; l2_request is ignored (the initiator's deassert is not yet visible). Go to IDLE.
- Latency: request sampled at edge k leads to l2_ready=1 during the cycle following edge k+LAT, where LAT is the per-type latency. Minimum request-to-request spacing is LAT+3 cycles.
- Input changes on l2_write_enable, l2_address or l2_write_data after acceptance are ignored; the latched copy is used.
- l2_request low while in WAIT does not abort the transaction; it completes and pulses l2_ready.
- Reset during WAIT abandons the transaction: no store write, no ready pulse, no count.
- Back-to-back writeback then fill (write, then read of a different address) must both complete correctly through RECOVER.
- Read-after-write to the same word returns the new data.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- Parameter checks: elaboration-time assertion fails if MEM_WORDS is not a power of two, or if either latency is 0.

Decomposition:
- Package l2_mem_pkg contains:
  - responder_state_t enum {IDLE, WAIT, RESPOND, RECOVER};
  - constant L2_DATA_WIDTH=32;
  - constant L2_ADDR_WIDTH=32;
  - constant L2_OFFSET_WIDTH=2.
- One sub-module, l2_storage_sram: single-port synchronous word array.
  - Ports: clk, write_enable, read_enable, index, write_data, read_data.
  - Registered read with 1-cycle latency, no reset.
  - Write has priority over read.

Test Plan:
- Reset, write 0xDEADBEEF to 0x0000_0040 (request held until ready) -> l2_ready pulses once exactly 2 cycles after acceptance; wr_count=1; busy high from acceptance until back in IDLE.
- Read 0x0000_0040 -> l2_ready 4 cycles after acceptance with l2_response_data=0xDEADBEEF; rd_count=1; data stays 0xDEADBEEF after ready falls.
- Address aliasing (MEM_WORDS=4096): write 0x1234_5678 to 0x0000_0004, then read 0x0000_4004 -> returns 0x1234_5678.
- L1-style writeback then fill: write 0xA5A5A5A5 to 0x100 with request held through ready, request low one cycle, then read 0x200 -> two separate ready pulses, no double acceptance of the write (wr_count=1, rd_count=1).
- Change l2_address/l2_write_data in the cycle after acceptance of a write to 0x80 with data 0x11 -> store holds 0x11 at 0x80; the new address is unchanged.
- Assert reset during WAIT of a write of 0x77 to 0x300 -> l2_ready never pulses, wr_count=0, and a later read of 0x300 returns the prior contents (not 0x77).
